// File: rtl/fpga_status_pkg.sv
// Shared types and constants for the status LED block and its code FSM.
package fpga_status_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_EXIT  = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE_ON  = 2'd1,
        PULSE_OFF = 2'd2,
        GAP       = 2'd3
    } code_state_e;

    localparam int GAP_TICKS  = 4;
    localparam int CODE_CNT_W = 5;

    // Number of pulses shown for a failing exit code; a zero low nibble maps to 16.
    function automatic logic [CODE_CNT_W-1:0] pulse_count(input logic [3:0] nibble);
        return (nibble == 4'd0) ? CODE_CNT_W'(16) : {1'b0, nibble};
    endfunction

endpackage

// File: rtl/fpga_status_code_fsm.sv
// Pulse-code generator for a failing exit value: code_n pulses of one tick on
// and one tick off, then a GAP_TICKS quiet period, repeating until reset.
module fpga_status_code_fsm
    import fpga_status_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick,
    input  logic                  fail,
    input  logic [CODE_CNT_W-1:0] code_n,
    output logic                  code_led
);

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    code_state_e           state;
    logic [CODE_CNT_W-1:0] pulse_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    // Walk the pulse pattern one step per tick; the pulse count reloads at each group start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (fail) begin
                        state     <= PULSE_ON;
                        pulse_cnt <= code_n;
                    end
                end
                PULSE_ON: begin
                    state <= PULSE_OFF;
                end
                PULSE_OFF: begin
                    if (pulse_cnt > CODE_CNT_W'(1)) begin
                        pulse_cnt <= pulse_cnt - CODE_CNT_W'(1);
                        state     <= PULSE_ON;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                        pulse_cnt <= code_n;
                        state     <= PULSE_ON;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign code_led = (state == PULSE_ON);

endmodule

// File: rtl/fpga_status_leds.sv
// Board status LEDs: per-channel OFF/ON/BLINK/EXIT modes driven from a free-running
// prescaler, with a one-shot exit-value latch feeding a shared pulse-code FSM.
module fpga_status_leds
    import fpga_status_pkg::*;
#(
    parameter int         NUM_LEDS   = 4,
    parameter int         CNT_WIDTH  = 27,
    parameter int         TICK_TAP   = 22,
    parameter int         EXIT_WIDTH = 32,
    parameter logic [1:0] RST_MODE   = 2'd3,
    localparam int        IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int        DIV_W      = $clog2(CNT_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_we_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [DIV_W-1:0]      cfg_div_i,
    input  logic                  exit_valid_i,
    input  logic [EXIT_WIDTH-1:0] exit_value_i,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  exit_latched_o,
    output logic [EXIT_WIDTH-1:0] exit_value_o
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CNT_WIDTH - 1);

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  tick;
    logic                  exit_fail;
    logic [CODE_CNT_W-1:0] code_n;
    logic                  code_led;
    logic [DIV_W-1:0]      cfg_div_clamped;
    logic [NUM_LEDS-1:0]   led_next;

    // Free-running prescaler; wraps naturally at its width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign tick = &cnt[TICK_TAP:0];

    // Capture only the first exit report; later ones are ignored until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_latched_o <= 1'b0;
            exit_value_o   <= '0;
        end else if (exit_valid_i && !exit_latched_o) begin
            exit_latched_o <= 1'b1;
            exit_value_o   <= exit_value_i;
        end
    end

    assign exit_fail = exit_latched_o && (exit_value_o != '0);
    assign code_n    = pulse_count(exit_value_o[3:0]);

    // Keep the blink tap inside the prescaler; the extra zero bit avoids a constant compare.
    always_comb begin
        cfg_div_clamped = cfg_div_i;
        if ({1'b0, cfg_div_i} > {1'b0, DIV_MAX}) begin
            cfg_div_clamped = DIV_MAX;
        end
    end

    fpga_status_code_fsm u_code_fsm (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .tick     (tick),
        .fail     (exit_fail),
        .code_n   (code_n),
        .code_led (code_led)
    );

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_mode_e        mode_q;
        logic [DIV_W-1:0] div_q;
        logic             sel;

        // An out-of-range index matches no channel, so it is dropped here.
        assign sel = cfg_we_i && (cfg_idx_i == IDX_W'(i));

        // Per-channel mode and blink tap configuration.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                mode_q <= led_mode_e'(RST_MODE);
                div_q  <= DIV_MAX;
            end else if (sel) begin
                mode_q <= led_mode_e'(cfg_mode_i);
                div_q  <= cfg_div_clamped;
            end
        end

        // Select this channel's LED source from its configured mode.
        always_comb begin
            led_next[i] = 1'b0;
            case (mode_q)
                LED_OFF:   led_next[i] = 1'b0;
                LED_ON:    led_next[i] = 1'b1;
                LED_BLINK: led_next[i] = cnt[div_q];
                LED_EXIT: begin
                    if (!exit_latched_o) begin
                        led_next[i] = cnt[CNT_WIDTH-1];
                    end else if (exit_fail) begin
                        led_next[i] = code_led;
                    end else begin
                        led_next[i] = 1'b1;
                    end
                end
                default:   led_next[i] = 1'b0;
            endcase
        end
    end

    // Register the LED pins so the board sees glitch-free drive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= led_next;
        end
    end

endmodule

// File: tb/tb_fpga_status_leds.sv
// Randomized scoreboard bench for fpga_status_leds with a pattern-level reference model.
module tb_fpga_status_leds;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int TT = 2;
    localparam int EW = 32;
    localparam int TICK_PERIOD = 1 << (TT + 1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cfg_we_i;
    logic [1:0]    cfg_idx_i;
    logic [1:0]    cfg_mode_i;
    logic [2:0]    cfg_div_i;
    logic          exit_valid_i;
    logic [EW-1:0] exit_value_i;
    logic [NL-1:0] led_o;
    logic          exit_latched_o;
    logic [EW-1:0] exit_value_o;

    typedef struct {
        logic [NL-1:0] led;
        logic          lat;
        logic [EW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state, described by the observable rules rather than RTL structure.
    int            m_cnt;
    int            m_mode[NL];
    int            m_div[NL];
    bit            m_lat;
    logic [EW-1:0] m_val;
    logic [NL-1:0] m_led;
    bit            m_code_active;
    int            m_pos;
    bit            m_code_led;

    always #5 clk = ~clk;

    fpga_status_leds #(
        .NUM_LEDS   (NL),
        .CNT_WIDTH  (CW),
        .TICK_TAP   (TT),
        .EXIT_WIDTH (EW),
        .RST_MODE   (2'd3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_div_i      (cfg_div_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .led_o          (led_o),
        .exit_latched_o (exit_latched_o),
        .exit_value_o   (exit_value_o)
    );

    // Advance the model by one clock edge and queue the outputs expected after it.
    task automatic modelStep(input bit rst, input bit we, input int idx, input int mode,
                             input int dv, input bit ev, input logic [EW-1:0] evv);
        logic [NL-1:0] nl;
        bit            tick;
        bit            fail;
        int            n;
        exp_t          e;
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < NL; i++) begin
                m_mode[i] = 3;
                m_div[i]  = CW - 1;
            end
            m_lat = 0;
            m_val = '0;
            m_led = '0;
            m_code_active = 0;
            m_pos = 0;
            m_code_led = 0;
        end else begin
            tick = ((m_cnt % TICK_PERIOD) == TICK_PERIOD - 1);
            fail = m_lat && (m_val != 0);
            n = ((m_val % 16) == 0) ? 16 : int'(m_val % 16);
            for (int i = 0; i < NL; i++) begin
                case (m_mode[i])
                    0: nl[i] = 1'b0;
                    1: nl[i] = 1'b1;
                    2: nl[i] = ((m_cnt >> m_div[i]) & 1) == 1;
                    default: begin
                        if (!m_lat)           nl[i] = ((m_cnt >> (CW - 1)) & 1) == 1;
                        else if (m_val == 0)  nl[i] = 1'b1;
                        else                  nl[i] = m_code_led;
                    end
                endcase
            end
            m_led = nl;
            if (tick) begin
                if (!m_code_active) begin
                    if (fail) begin
                        m_code_active = 1;
                        m_pos = 0;
                    end
                end else begin
                    m_pos = (m_pos + 1) % (2 * n + 4);
                end
                m_code_led = m_code_active && (m_pos < 2 * n) && ((m_pos % 2) == 0);
            end
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (we && idx < NL) begin
                m_mode[idx] = mode;
                m_div[idx]  = (dv > CW - 1) ? CW - 1 : dv;
            end
            if (ev && !m_lat) begin
                m_lat = 1;
                m_val = evv;
            end
        end
        e.led = m_led;
        e.lat = m_lat;
        e.val = m_val;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs away from the active edge and record the expectation.
    task automatic applyStimulus(input bit rst, input bit we, input int idx, input int mode,
                                 input int dv, input bit ev, input logic [EW-1:0] evv);
        @(negedge clk);
        rst_i        = rst;
        cfg_we_i     = we;
        cfg_idx_i    = 2'(idx);
        cfg_mode_i   = 2'(mode);
        cfg_div_i    = 3'(dv);
        exit_valid_i = ev;
        exit_value_i = evv;
        modelStep(rst, we, idx, mode, dv, ev, evv);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, $urandom);
    endtask

    task automatic randomCycles(input int n, input int we_odds, input int ev_odds);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, ($urandom % we_odds) == 0, $urandom % 4, $urandom % 4,
                          $urandom % 8, ($urandom % ev_odds) == 0,
                          (($urandom % 4) == 0) ? '0 : EW'($urandom));
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (led_o !== e.led) begin
            errors++;
            $display("[TB] FAIL led_o cycle %0d: got %b expected %b", cycle, led_o, e.led);
        end
        checks++;
        if (exit_latched_o !== e.lat) begin
            errors++;
            $display("[TB] FAIL exit_latched_o cycle %0d: got %b expected %b", cycle, exit_latched_o, e.lat);
        end
        checks++;
        if (exit_value_o !== e.val) begin
            errors++;
            $display("[TB] FAIL exit_value_o cycle %0d: got %h expected %h", cycle, exit_value_o, e.val);
        end
    endtask

    // Monitor: compare DUT outputs shortly after each edge against the queued expectation.
    always @(posedge clk) begin
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        rst_i = 1'b1;
        cfg_we_i = 1'b0;
        cfg_idx_i = '0;
        cfg_mode_i = '0;
        cfg_div_i = '0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;

        $display("[TB] reset and heartbeat");
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(300);

        $display("[TB] blink on channel 1 and random configuration");
        applyStimulus(0, 1, 1, 2, 1, 0, '0);
        idleCycles(20);
        randomCycles(400, 6, 1000000);

        $display("[TB] passing exit, later pulse ignored");
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(5);
        applyStimulus(0, 0, 0, 0, 0, 1, '0);
        idleCycles(10);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'd7);
        idleCycles(50);

        $display("[TB] failing exit code 3, reset during a pulse");
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'd3);
        idleCycles(200);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (led_o[0] === 1'b1) found = 1;
            else idleCycles(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL pulse_wait: got no pulse within 100 cycles, required a pulse");
        end
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(150);

        $display("[TB] failing exit code 0x10");
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10);
        idleCycles(650);

        $display("[TB] random exits with random configuration");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, '0);
            idleCycles(2);
            randomCycles(300, 20, 30);
        end

        $display("[TB] simultaneous config write and exit");
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        idleCycles(3);
        applyStimulus(0, 1, 0, 1, 0, 1, 32'h5);
        idleCycles(30);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
